seg_scan_ctrl: RTL

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_pkg.sv | 21 ++
 rtl/seg_decode.sv | 18 +
 rtl/seg_scan_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg_pkg;

  typedef enum logic {
    StGuard,
    StDrive
  } state_e;

  localparam logic [4:0] CODE_DASH  = 5'd16;
  localparam logic [4:0] CODE_BLANK = 5'd17;

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  // Active-low {g,f,e,d,c,b,a}; entry 0 is the rightmost element.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seg_decode.sv
// Character code to active-low segment pattern: 0-15 hex, 16 dash, others blank.
module seg_decode
  import seg_pkg::*;
(
  input  logic [4:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    if (code < 5'd16) begin
      seg = HEX_SEG[code[3:0]];
    end else if (code == CODE_DASH) begin
      seg = SEG_DASH;
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner with guard dead time per slot.
// Define SEG_LZ_BLANK_EN to blank leading zeros on digits 3..1.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned GUARD_CYC   = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] digit0,
  input  logic [4:0] digit1,
  input  logic [4:0] digit2,
  input  logic [4:0] digit3,
  input  logic [3:0] dp_in,
  input  logic       blank_all,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       scan_tick
);

  localparam int unsigned CntW = $clog2(REFRESH_DIV);
  localparam logic [CntW-1:0] GuardLast = CntW'(GUARD_CYC - 1);
  localparam logic [CntW-1:0] DriveLast = CntW'(REFRESH_DIV - GUARD_CYC - 1);

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [1:0]      idx_q;
  logic [4:0]      hold_code_q, hold_code_d;
  logic            hold_dp_q, hold_dp_d;

  logic [4:0] digit_sel;
  logic       dp_sel;
  logic [4:0] capture_code;
  logic       capture;
  logic       drive_next;
  logic [6:0] dec_seg;

  always_comb begin
    digit_sel = digit0;
    unique case (idx_q)
      2'd0: digit_sel = digit0;
      2'd1: digit_sel = digit1;
      2'd2: digit_sel = digit2;
      2'd3: digit_sel = digit3;
    endcase
    dp_sel = dp_in[idx_q];
  end

`ifdef SEG_LZ_BLANK_EN
  logic lz_blank;

  // A digit is a leading zero when it and every higher digit are zero.
  always_comb begin
    lz_blank = 1'b0;
    unique case (idx_q)
      2'd0: lz_blank = 1'b0;
      2'd1: lz_blank = (digit1 == 5'd0) && (digit2 == 5'd0) && (digit3 == 5'd0);
      2'd2: lz_blank = (digit2 == 5'd0) && (digit3 == 5'd0);
      2'd3: lz_blank = (digit3 == 5'd0);
    endcase
    capture_code = lz_blank ? CODE_BLANK : digit_sel;
  end
`else
  assign capture_code = digit_sel;
`endif

  assign capture    = (state_q == StGuard) && (cnt_q == GuardLast);
  assign drive_next = capture || ((state_q == StDrive) && (cnt_q != DriveLast));

  // Decode the value the holding register will carry next cycle, so the first
  // drive cycle already shows the freshly captured digit.
  assign hold_code_d = capture ? capture_code : hold_code_q;
  assign hold_dp_d   = capture ? dp_sel : hold_dp_q;

  seg_decode u_seg_decode (
    .code(hold_code_d),
    .seg (dec_seg)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StGuard;
      cnt_q       <= '0;
      idx_q       <= 2'd0;
      hold_code_q <= CODE_BLANK;
      hold_dp_q   <= 1'b0;
      an          <= 4'b1111;
      seg         <= SEG_OFF;
      dp          <= 1'b1;
      scan_tick   <= 1'b0;
    end else begin
      hold_code_q <= hold_code_d;
      hold_dp_q   <= hold_dp_d;
      scan_tick   <= capture;

      unique case (state_q)
        StGuard: begin
          if (cnt_q == GuardLast) begin
            state_q <= StDrive;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDrive: begin
          if (cnt_q == DriveLast) begin
            state_q <= StGuard;
            cnt_q   <= '0;
            idx_q   <= idx_q + 2'd1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      endcase

      if (blank_all || !drive_next) begin
        an  <= 4'b1111;
        seg <= SEG_OFF;
        dp  <= 1'b1;
      end else begin
        an  <= ~(4'b0001 << idx_q);
        seg <= dec_seg;
        dp  <= ~hold_dp_d;
      end
    end
  end

endmodule
